// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter: edge/level pending capture, lowest-index-wins selection,
// and a request/ack handshake that holds the offered id until it retires.
//
// state | meaning
// ARB   | no request offered; pick the lowest pending, unmasked source
// HOLD  | irq_o high, irq_id_o frozen until ack or withdraw
// COOL  | one idle cycle after an ack, covering the controller's DONE cycle
module zeroriscy_irq_arbiter #(
  parameter int NUM_IRQ = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic [NUM_IRQ-1:0] irq_edge_cfg_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_COOL} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] line_q, line_d;
  logic               irq_q, irq_d;
  logic [4:0]         id_q, id_d;

  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [4:0]         win_id;
  logic               win_vld;
  logic               held_cand;
  logic               ack_hold;

  assign cand     = pend_q & irq_mask_i;
  assign win_vld  = |cand;
  assign ack_hold = (state_q == ST_HOLD) && irq_ack_i;

  // Scan from the top so the lowest set index is the last write.
  always_comb begin
    win_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) win_id = 5'(k);
    end
  end

  always_comb begin
    held_cand = 1'b0;
    ack_clr   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (id_q == 5'(k)) begin
        held_cand  = cand[k];
        ack_clr[k] = ack_hold;
      end
    end
  end

  // Edge sources: a fresh rising edge beats a same-cycle ack clear.
  always_comb begin
    line_d = irq_lines_i;
    pend_d = (irq_edge_cfg_i & ((irq_lines_i & ~line_q) | (pend_q & ~ack_clr)))
           | (~irq_edge_cfg_i & irq_lines_i);
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    case (state_q)
      ST_ARB: begin
        irq_d = 1'b0;
        if (win_vld) begin
          irq_d   = 1'b1;
          id_d    = win_id;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        irq_d = 1'b1;
        if (irq_ack_i) begin
          irq_d   = 1'b0;
          state_d = ST_COOL;
        end else if (!held_cand) begin
          irq_d   = 1'b0;
          state_d = ST_ARB;
        end
      end
      ST_COOL: begin
        irq_d   = 1'b0;
        state_d = ST_ARB;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      pend_q  <= '0;
      line_q  <= '0;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

  assign irq_o         = irq_q;
  assign irq_id_o      = id_q;
  assign irq_pending_o = pend_q;

endmodule

// File: tb/tb_zeroriscy_irq_arbiter.sv
// Bench for zeroriscy_irq_arbiter: directed scenarios with literal checks plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_zeroriscy_irq_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] lines, edge_cfg, mask;
  logic         ack;
  logic         irq_o;
  logic [4:0]   irq_id_o;
  logic [N-1:0] pending_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: offered id (-1 when nothing is offered) and a cooldown flag.
  bit [N-1:0] m_pend, m_line;
  int         m_offer, m_cool, m_id;

  zeroriscy_irq_arbiter #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .irq_lines_i(lines), .irq_edge_cfg_i(edge_cfg),
    .irq_mask_i(mask), .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_ack_i(ack),
    .irq_pending_o(pending_o));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] cand, np;
    bit acked;
    if (!rst_n) begin
      m_pend = '0; m_line = '0; m_offer = -1; m_cool = 0; m_id = 0;
      return;
    end
    cand  = m_pend & mask;
    acked = (m_offer >= 0) && ack;
    for (int k = 0; k < N; k++) begin
      if (edge_cfg[k])
        np[k] = (lines[k] && !m_line[k]) || (m_pend[k] && !(acked && m_offer == k));
      else
        np[k] = lines[k];
    end
    if (m_offer >= 0) begin
      if (ack) begin
        m_offer = -1; m_cool = 1;
      end else if (!cand[m_offer]) begin
        m_offer = -1;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else if (cand != '0) begin
      for (int k = N - 1; k >= 0; k--) if (cand[k]) m_offer = k;
      m_id = m_offer;
    end
    m_line = lines;
    m_pend = np;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("irq_o", {31'd0, irq_o}, {31'd0, m_offer >= 0});
    check("pending", pending_o, m_pend);
    if (m_offer >= 0) check("irq_id", {27'd0, irq_id_o}, m_id);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lines = '0; ack = 1'b0;
    cycn(2);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; lines = '0; edge_cfg = '1; mask = '1; ack = 1'b0;
    m_pend = '0; m_line = '0; m_offer = -1; m_cool = 0; m_id = 0;
    cycn(2);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_id", {27'd0, irq_id_o}, 32'd0);
    check("rst_pend", pending_o, 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: edge source 3
    lines = 32'h8; cyc();
    check("t1_pend3", pending_o, 32'h8);
    check("t1_irq_early", {31'd0, irq_o}, 32'd0);
    lines = '0; cyc();
    check("t1_irq", {31'd0, irq_o}, 32'd1);
    check("t1_id", {27'd0, irq_id_o}, 32'd3);
    cycn(2);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("t1_ack_irq", {31'd0, irq_o}, 32'd0);
    check("t1_ack_pend", pending_o, 32'd0);
    cycn(3);

    // 2: level source 5
    edge_cfg[5] = 1'b0;
    lines = 32'h20; cycn(2);
    check("t2_id", {27'd0, irq_id_o}, 32'd5);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("t2_pend_kept", pending_o, 32'h20);
    cyc();
    check("t2_cool", {31'd0, irq_o}, 32'd0);
    cyc();
    check("t2_reoffer", {31'd0, irq_o}, 32'd1);
    check("t2_reoffer_id", {27'd0, irq_id_o}, 32'd5);
    lines = '0; cyc();
    check("t2_drop_pend", pending_o, 32'd0);
    cycn(3);
    edge_cfg[5] = 1'b1;

    // 3: simultaneous 7 and 2, later arrival of 1 does not preempt
    lines = 32'h84; cyc(); lines = '0; cyc();
    check("t3_id2", {27'd0, irq_id_o}, 32'd2);
    ack = 1'b1; cyc(); ack = 1'b0;
    cycn(2);
    check("t3_id7", {27'd0, irq_id_o}, 32'd7);
    lines = 32'h2; cyc(); lines = '0; cycn(2);
    check("t3_nopreempt", {27'd0, irq_id_o}, 32'd7);
    ack = 1'b1; cyc(); ack = 1'b0; cycn(2);
    check("t3_id1", {27'd0, irq_id_o}, 32'd1);
    ack = 1'b1; cyc(); ack = 1'b0; cycn(3);

    // 4: level source 4 withdrawn by line drop, then by mask
    edge_cfg[4] = 1'b0;
    lines = 32'h10; cycn(2);
    check("t4_id4", {27'd0, irq_id_o}, 32'd4);
    lines = '0; cycn(2);
    check("t4_withdraw", {31'd0, irq_o}, 32'd0);
    lines = 32'h10; cycn(3);
    check("t4_reheld", {31'd0, irq_o}, 32'd1);
    mask[4] = 1'b0; cyc();
    check("t4_mask_withdraw", {31'd0, irq_o}, 32'd0);
    mask[4] = 1'b1; lines = '0; cycn(3);
    edge_cfg[4] = 1'b1;

    // 5: edge source 0, new edge in the ack cycle
    lines = 32'h1; cyc(); lines = '0; cyc();
    check("t5_id0", {27'd0, irq_id_o}, 32'd0);
    check("t5_irq", {31'd0, irq_o}, 32'd1);
    lines = 32'h1; ack = 1'b1; cyc(); ack = 1'b0; lines = '0;
    check("t5_pend_kept", pending_o, 32'h1);
    cycn(2);
    check("t5_reoffer", {31'd0, irq_o}, 32'd1);
    ack = 1'b1; cyc(); ack = 1'b0; cycn(3);

    // 6: reset during HOLD with line held through release
    lines = 32'h40; cycn(2);
    check("t6_held", {31'd0, irq_o}, 32'd1);
    rst_n = 1'b0; cyc();
    check("t6_rst_irq", {31'd0, irq_o}, 32'd0);
    check("t6_rst_pend", pending_o, 32'd0);
    rst_n = 1'b1; cyc();
    check("t6_edge_pend", pending_o, 32'h40);
    cyc();
    check("t6_offer", {31'd0, irq_o}, 32'd1);
    check("t6_offer_id", {27'd0, irq_id_o}, 32'd6);
    lines = '0; ack = 1'b1; cyc(); ack = 1'b0;
    do_reset();

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      lines = $urandom & $urandom & $urandom;
      ack   = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) mask = ~($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0 && m_offer < 0) edge_cfg = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
